bus_arbiter: RTL
================

# bus_arbiter

Round-robin arbiter for the shared snoopy-cache bus. Each CPU controller raises a request whenever it has a pending bus command and keeps it raised for the whole multi-word transaction. The arbiter grants exactly one device at a time and holds that grant until the owner withdraws its request. A turnaround cycle and a rotating priority pointer guarantee fairness, and a sticky watchdog flags owners that hold the bus too long.

## Interface
- DEVICE_COUNT, default 4: number of requesting devices; must be ≥ 2; any value allowed, not restricted to powers of two.
- TIMEOUT_CYCLES, default 1024: consecutive granted cycles after which the watchdog fires; must be ≥ 1.
- ID_WIDTH, default $clog2(DEVICE_COUNT): width of the owner index.

Ports:
- clock, input, 1: single clock; all state updates on the rising edge.
- reset, input, 1: asynchronous, active-low reset.
- requests, input, DEVICE_COUNT: bit i is the request from device i (the device's ArbiterInterface request).
- grants, output, DEVICE_COUNT: one-hot or zero; bit i is the grant to device i.
- owner, output, ID_WIDTH: index of the granted device; valid only while busy = 1.
- busy, output, 1: 1 in the GRANTED state.
- timeoutError, output, 1: sticky watchdog flag.

## Operation
- All outputs are registered.
- Reset values: grants = 0, owner = 0, busy = 0, timeoutError = 0, priority pointer = 0, hold counter = 0, state = IDLE.
- State machine:
  - IDLE:
    - If requests ≠ 0, search upward from the pointer, wrapping DEVICE_COUNT−1 → 0. The first set bit is the winner.
    - grants <= onehot(winner), owner <= winner, busy <= 1, hold counter <= 1, state -> GRANTED.
    - If requests = 0, remain in IDLE with all outputs low.
  - GRANTED:
    - While requests[owner] = 1: hold grant, owner and busy unchanged; hold counter increments and saturates at TIMEOUT_CYCLES.
    - When the counter reaches TIMEOUT_CYCLES while requests[owner] is still 1, timeoutError <= 1.
    - No preemption: other requests are ignored, so a block transfer is never split.
    - When requests[owner] = 0: grants <= 0, busy <= 0, pointer <= (owner + 1) mod DEVICE_COUNT, hold counter <= 0, state -> TURNAROUND.
  - TURNAROUND: exactly one cycle with all grants low, then state -> IDLE. Requests are not evaluated in this cycle.
- Pointer wrap: when owner = DEVICE_COUNT−1, the pointer becomes 0. The wrap must be correct for non-power-of-two DEVICE_COUNT; the pointer never holds a value ≥ DEVICE_COUNT.
- timeoutError clears only on reset. It has no effect on the grant.
- Requests from non-owners while GRANTED or TURNAROUND are simply re-evaluated in IDLE. There is no queueing and no loss, because requesters hold their request level.
- A request that drops in the same cycle it would have won is not granted: arbitration uses the value sampled at the IDLE edge.

## Timing
- Grant latency: request sampled high at IDLE edge k → grant high after edge k. Minimum one cycle from request assertion.
- Release: requests[owner] sampled low at edge k → grant low after edge k.
  - TURNAROUND occupies cycle k..k+1; IDLE is re-entered at edge k+1.
  - The next grant appears after edge k+2 at the earliest.
- Back-to-back ownership by different devices is therefore separated by exactly 2 grant-low cycles (TURNAROUND + IDLE evaluation).
- Asynchronous reset mid-transaction: grants, busy and timeoutError drop immediately on reset falling. Nothing is retained; after reset release, arbitration restarts from pointer 0.
- Watchdog: with a continuous hold, timeoutError rises after the edge at which the counter reaches TIMEOUT_CYCLES, i.e. at the TIMEOUT_CYCLES-th granted edge.
- Worst-case wait for any requester while the others release normally: DEVICE_COUNT−1 ownerships.

## Test plan
All scenarios use DEVICE_COUNT = 4 and TIMEOUT_CYCLES = 8 unless noted.
- Reset, then requests = 4'b0000 for 5 cycles → grants = 0, busy = 0, owner = 0 throughout. Pulse reset low while device 2 is granted → grants = 0 immediately.
- requests = 4'b0101 from reset → grant 4'b0001 one edge later. Drop req0 → grants 0 for 2 cycles, then 4'b0100.
- Rotation and wrap: all four requesting, each releasing after 3 cycles → grant order 0,1,2,3,0; pointer never exceeds 3. Repeat with DEVICE_COUNT = 3 → order 0,1,2,0.
- No preemption: device 1 granted, req3 rises and stays high, req1 held 20 cycles → grants stay 4'b0010 for all 20 cycles. timeoutError = 1 after the 8th granted edge. After release, 4'b1000 is granted 2 cycles later. timeoutError remains 1.
- Release during arbitration: req2 drops in the TURNAROUND cycle while req1 rises → the next grant goes to device 1 only. No one-cycle grant glitch to device 2.
- Hold for exactly 7 cycles → timeoutError stays 0. Hold for exactly 8 cycles → timeoutError = 1.

Source files
------------

// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - round-robin bus arbiter with turnaround cycle and sticky hold watchdog
module bus_arbiter #(
  parameter int DEVICE_COUNT   = 4,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int ID_WIDTH       = $clog2(DEVICE_COUNT)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [DEVICE_COUNT-1:0] requests,
  output logic [DEVICE_COUNT-1:0] grants,
  output logic [ID_WIDTH-1:0]     owner,
  output logic                    busy,
  output logic                    timeoutError
);

  localparam int HOLD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int SUM_W  = ID_WIDTH + 1;
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(TIMEOUT_CYCLES);
  localparam logic [SUM_W-1:0]  DEV_N    = SUM_W'(DEVICE_COUNT);

  localparam logic [1:0] ST_IDLE       = 2'd0;
  localparam logic [1:0] ST_GRANTED    = 2'd1;
  localparam logic [1:0] ST_TURNAROUND = 2'd2;

  logic [1:0]                state;
  logic [ID_WIDTH-1:0]       pointer;
  logic [HOLD_W-1:0]         hold_count;

  logic [2*DEVICE_COUNT-1:0] req_twice;
  logic [2*DEVICE_COUNT-1:0] req_rot;
  logic [ID_WIDTH-1:0]       offset;
  logic [SUM_W-1:0]          win_sum;
  logic [ID_WIDTH-1:0]       winner;
  logic [DEVICE_COUNT-1:0]   winner_onehot;
  logic [SUM_W-1:0]          owner_inc;
  logic [ID_WIDTH-1:0]       next_pointer;

  // Rotating the doubled vector puts requests[pointer] at bit 0, so the
  // lowest set bit is the distance from the pointer to the winner.
  assign req_twice = {requests, requests};
  assign req_rot   = req_twice >> pointer;

  always_comb begin
    offset = '0;
    for (int k = DEVICE_COUNT - 1; k >= 0; k--) begin
      if (req_rot[k]) offset = ID_WIDTH'(k);
    end
    win_sum = {1'b0, pointer} + {1'b0, offset};
    if (win_sum >= DEV_N) win_sum = win_sum - DEV_N;
    winner        = win_sum[ID_WIDTH-1:0];
    winner_onehot = DEVICE_COUNT'(1) << winner;
  end

  // Explicit compare keeps the wrap correct for non-power-of-two counts.
  assign owner_inc    = {1'b0, owner} + SUM_W'(1);
  assign next_pointer = (owner_inc == DEV_N) ? '0 : owner_inc[ID_WIDTH-1:0];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= ST_IDLE;
      pointer      <= '0;
      hold_count   <= '0;
      grants       <= '0;
      owner        <= '0;
      busy         <= 1'b0;
      timeoutError <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (|requests) begin
            grants     <= winner_onehot;
            owner      <= winner;
            busy       <= 1'b1;
            hold_count <= HOLD_W'(1);
            state      <= ST_GRANTED;
            if (HOLD_W'(1) == HOLD_MAX) timeoutError <= 1'b1;
          end
        end
        ST_GRANTED: begin
          if (requests[owner]) begin
            if (hold_count != HOLD_MAX) begin
              hold_count <= hold_count + 1'b1;
              if (hold_count + 1'b1 == HOLD_MAX) timeoutError <= 1'b1;
            end
          end else begin
            grants     <= '0;
            busy       <= 1'b0;
            pointer    <= next_pointer;
            hold_count <= '0;
            state      <= ST_TURNAROUND;
          end
        end
        ST_TURNAROUND: state <= ST_IDLE;
        default:       state <= ST_IDLE;
      endcase
    end
  end

endmodule
